// File: rtl/cpu_types_pkg.sv
// Shared CPU types: the machine word, RAM handshake state and arbiter grant state.
// Also holds the saturating streak increment used by the optional fairness logic.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

  localparam int STREAK_W = 4;

  function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] s);
    return (s == {STREAK_W{1'b1}}) ? s : s + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arb_fairness.sv
// Streak counter of data completions seen while an instruction fetch waits;
// asserts force_i once the streak reaches STREAK_MAX so the fetch gets a turn.
module mem_arb_fairness
  import cpu_types_pkg::*;
#(
  parameter int STREAK_MAX = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic iREN,
  input  logic d_done,
  input  logic i_done,
  output logic force_i
);

  logic [STREAK_W-1:0] streak;

  always_ff @(posedge CLK) begin
    if (RST) begin
      streak <= '0;
    end else if (i_done) begin
      streak <= '0;
    end else if (d_done) begin
      streak <= iREN ? streak_inc(streak) : '0;
    end
  end

  assign force_i = iREN && (streak >= STREAK_W'(STREAK_MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data ports; data has priority.
// Optional fetch-starvation guard enabled by defining MEM_ARB_FAIRNESS_EN.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STREAK_MAX = 4
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      arb_err
);

  arb_state_t state, next;
  logic       d_req;
  logic       force_i;

  assign d_req = dREN | dWEN;

`ifdef MEM_ARB_FAIRNESS_EN
  logic d_done, i_done;

  assign d_done = (state == DGNT) && d_req && (ramstate == ACCESS);
  assign i_done = (state == IGNT) && iREN && (ramstate == ACCESS);

  mem_arb_fairness #(
    .STREAK_MAX(STREAK_MAX)
  ) u_fairness (
    .CLK    (CLK),
    .RST    (RST),
    .iREN   (iREN),
    .d_done (d_done),
    .i_done (i_done),
    .force_i(force_i)
  );
`else
  // STREAK_MAX is legal only in 1..15, so strict priority never forces a fetch.
  assign force_i = (STREAK_MAX == 0);
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next     = state;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = iREN;
    dwait    = d_req;
    iload    = '0;
    dload    = '0;
    arb_err  = 1'b0;
    case (state)
      IDLE: begin
        if (force_i) begin
          next = IGNT;
        end else if (d_req) begin
          next = DGNT;
        end else if (iREN) begin
          next = IGNT;
        end
      end
      IGNT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        // A withdrawn request abandons the access without completing it.
        if (!iREN) begin
          next = IDLE;
        end else if (ramstate == ACCESS) begin
          iwait = 1'b0;
          iload = ramload;
          next  = IDLE;
        end else if (ramstate == ERROR) begin
          iwait   = 1'b0;
          arb_err = 1'b1;
          next    = IDLE;
        end
      end
      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (!d_req) begin
          next = IDLE;
        end else if (ramstate == ACCESS) begin
          dwait = 1'b0;
          dload = ramload;
          next  = IDLE;
        end else if (ramstate == ERROR) begin
          dwait   = 1'b0;
          arb_err = 1'b1;
          next    = IDLE;
        end
      end
      default: next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a grant-level reference model checked every cycle.
// Build with MEM_ARB_FAIRNESS_EN defined to exercise the fetch-starvation guard.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int SMAX = 2;
`ifdef MEM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic      CLK = 1'b0;
  logic      RST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore, ramload;
  ramstate_t ramstate;
  logic      iwait, dwait, ramREN, ramWEN, arb_err;
  word_t     iload, dload, ramaddr, ramstore;

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  mem_arbiter #(.STREAK_MAX(SMAX)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .arb_err(arb_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the RAM (0 none, 1 fetch, 2 data) and the data streak.
  int mg = 0;
  int ms = 0;

  always @(posedge CLK) begin
    logic dreq, fin;
    dreq = dREN | dWEN;
    fin  = (ramstate == ACCESS) || (ramstate == ERROR);
    if (RST) begin
      mg <= 0;
      ms <= 0;
    end else if (mg == 0) begin
      if (FAIR && ms >= SMAX && iREN) mg <= 1;
      else if (dreq) mg <= 2;
      else if (iREN) mg <= 1;
    end else if (mg == 1) begin
      if (!iREN || fin) mg <= 0;
      if (iREN && ramstate == ACCESS) ms <= 0;
    end else begin
      if (!dreq || fin) mg <= 0;
      if (dreq && ramstate == ACCESS) ms <= iREN ? ((ms < 15) ? ms + 1 : ms) : 0;
    end
  end

  always @(negedge CLK) begin
    logic        dreq, e_iw, e_dw, e_rr, e_rw, e_err;
    logic [31:0] e_il, e_dl, e_ra, e_rs;
    if (armed) begin
      dreq  = dREN | dWEN;
      e_iw  = iREN;  e_dw = dreq;
      e_il  = 0;     e_dl = 0;
      e_rr  = 0;     e_rw = 0;  e_ra = 0;  e_rs = 0;
      e_err = 0;
      if (mg == 1) begin
        e_rr = 1; e_ra = iaddr;
        if (iREN && ramstate == ACCESS) begin e_iw = 0; e_il = ramload; end
        if (iREN && ramstate == ERROR)  begin e_iw = 0; e_err = 1; end
      end else if (mg == 2) begin
        e_rw = dWEN; e_rr = dREN & ~dWEN; e_ra = daddr; e_rs = dstore;
        if (dreq && ramstate == ACCESS) begin e_dw = 0; e_dl = ramload; end
        if (dreq && ramstate == ERROR)  begin e_dw = 0; e_err = 1; end
      end
      chk("m_iwait", iwait, e_iw);
      chk("m_dwait", dwait, e_dw);
      chk("m_iload", iload, e_il);
      chk("m_dload", dload, e_dl);
      chk("m_ramREN", ramREN, e_rr);
      chk("m_ramWEN", ramWEN, e_rw);
      chk("m_ramaddr", ramaddr, e_ra);
      if (mg != 1) chk("m_ramstore", ramstore, e_rs);
      chk("m_arb_err", arb_err, e_err);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic at_neg();
    @(negedge CLK);
  endtask

  initial begin
    byte grants[$];
    bit  iw_low;
    RST = 1; iREN = 1; iaddr = 32'h40; dREN = 0; dWEN = 0;
    daddr = 0; dstore = 0; ramstate = FREE; ramload = 0;

    // reset
    step(); armed = 1;
    at_neg();
    chk("rst_ramREN", ramREN, 0);
    chk("rst_iwait", iwait, 1);
    chk("rst_arb_err", arb_err, 0);
    chk("rst_ramaddr", ramaddr, 0);
    step();
    step(); RST = 0; ramstate = BUSY;
    at_neg(); chk("idle_ramREN", ramREN, 0);

    // instruction read, two BUSY cycles then ACCESS
    step();
    at_neg(); chk("ird_ramREN", ramREN, 1); chk("ird_ramaddr", ramaddr, 32'h40);
    chk("ird_iwait_busy", iwait, 1);
    step();
    step(); ramstate = ACCESS; ramload = 32'h8C22_0004;
    at_neg(); chk("ird_iwait_done", iwait, 0); chk("ird_iload", iload, 32'h8C22_0004);
    step(); iREN = 0; ramstate = FREE; ramload = 0;
    at_neg(); chk("ird_after_ramREN", ramREN, 0);

    // simultaneous requests: data first, one IDLE, then fetch
    step(); iREN = 1; iaddr = 32'h80; dREN = 1; daddr = 32'h100;
    step(); ramstate = ACCESS; ramload = 32'h1111_2222;
    at_neg(); chk("sim_d_ramaddr", ramaddr, 32'h100); chk("sim_d_dload", dload, 32'h1111_2222);
    chk("sim_iwait_held", iwait, 1);
    step(); dREN = 0; ramstate = FREE;
    at_neg(); chk("sim_gap_ramREN", ramREN, 0);
    step(); ramstate = ACCESS; ramload = 32'h3333_4444;
    at_neg(); chk("sim_i_ramaddr", ramaddr, 32'h80); chk("sim_i_iload", iload, 32'h3333_4444);
    step(); iREN = 0; ramstate = FREE;

    // write beats read, RAM reports ERROR
    step(); dREN = 1; dWEN = 1; daddr = 32'h200; dstore = 32'hDEAD_BEEF;
    step(); ramstate = BUSY;
    at_neg(); chk("wr_ramWEN", ramWEN, 1); chk("wr_ramREN", ramREN, 0);
    chk("wr_ramstore", ramstore, 32'hDEAD_BEEF);
    step(); ramstate = ERROR; ramload = 32'hFFFF_FFFF;
    at_neg(); chk("err_dwait", dwait, 0); chk("err_dload", dload, 0); chk("err_pulse", arb_err, 1);
    step(); dREN = 0; dWEN = 0; ramstate = FREE; ramload = 0;
    at_neg(); chk("err_pulse_end", arb_err, 0); chk("err_idle_ramWEN", ramWEN, 0);

    // withdrawal of a fetch while BUSY
    step(); iREN = 1; iaddr = 32'h44;
    step(); ramstate = BUSY;
    at_neg(); chk("wd_ramREN", ramREN, 1);
    step(); iREN = 0;
    at_neg(); chk("wd_arb_err", arb_err, 0);
    step(); ramstate = FREE;
    at_neg(); chk("wd_idle_ramREN", ramREN, 0); chk("wd_idle_err", arb_err, 0);

    // reset in the middle of a data grant
    step(); dREN = 1; daddr = 32'h300;
    step(); ramstate = BUSY;
    at_neg(); chk("rg_ramREN", ramREN, 1);
    step(); RST = 1;
    step(); RST = 0; dREN = 0; ramstate = FREE;
    at_neg(); chk("rg_after_ramREN", ramREN, 0);

    // continuous data traffic with a fetch pending
    step(); dREN = 1; daddr = 32'h500; iREN = 1; iaddr = 32'h600; ramstate = ACCESS;
    ramload = 32'h0000_00AA;
    iw_low = 0;
    for (int i = 0; i < 12; i++) begin
      at_neg();
      if (ramREN) grants.push_back((ramaddr == 32'h500) ? "D" : "I");
      if (!iwait) iw_low = 1;
      step();
    end
    dREN = 0; iREN = 0; ramstate = FREE;
    chk("fair_grant_count", grants.size(), 6);
    if (grants.size() == 6) begin
`ifdef MEM_ARB_FAIRNESS_EN
      string exp_order;
      exp_order = "DDIDDI";
      for (int i = 0; i < 6; i++) chk("fair_order", grants[i], exp_order[i]);
`else
      for (int i = 0; i < 6; i++) chk("strict_order", grants[i], "D");
      chk("strict_iwait_held", iw_low, 0);
`endif
    end

    step(); step();
    at_neg();
    chk("end_ramREN", ramREN, 0);
    armed = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
